// File: rtl/hamming_seq_ctrl.sv
// SECDED (8,4) check sequencer: debounced press captures switches,
// drives the external syndrome checker, classifies and corrects.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   btn_i               raw push-button (async, active-high)
//   conmutador_4        reference data {w0,w1,w2,w3}
//   conmutador_8        received codeword {p0,p1,w0,p2,w1,w2,w3,g0}
//   chk_word_o          codeword presented to the checker
//   chk_sindrome_i      checker result {g,s2,s1,s0}
//   busy_o, valid_o     sequence running / results valid
//   err_type_o          00 none, 01 single, 10 double, 11 g0-only
//   err_pos_o           corrected Hamming position (0 if none)
//   corr_word_o         corrected codeword
//   corr_data_o         data bits of corr_word_o
//   match_o             corrected data equals reference
module hamming_seq_ctrl #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter int          CHK_LAT    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_i,
  input  logic [3:0] conmutador_4,
  input  logic [7:0] conmutador_8,
  output logic [7:0] chk_word_o,
  input  logic [3:0] chk_sindrome_i,
  output logic       busy_o,
  output logic       valid_o,
  output logic [1:0] err_type_o,
  output logic [2:0] err_pos_o,
  output logic [7:0] corr_word_o,
  output logic [3:0] corr_data_o,
  output logic       match_o
);

  localparam int WW = (CHK_LAT > 2) ? $clog2(CHK_LAT) : 1;
  localparam logic [WW-1:0] WAIT_LAST =
    WW'((CHK_LAT > 1) ? (CHK_LAT - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_WAIT,
    S_CLASSIFY,
    S_DONE
  } state_t;

  // ---------------- button path ----------------
  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic        r_acc;
  logic        r_arm;
  logic        r_start;
  logic [15:0] r_deb_cnt;

  logic w_edge;
  logic w_diff;

  assign w_edge = r_sync2 ^ r_sync3;
  // Until a released level has been accepted once after reset, the
  // counter keeps running so the idle level can arm the press detector.
  // A button held through reset is therefore never reported as a press.
  assign w_diff = (r_sync2 != r_acc) | ~r_arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync3   <= 1'b0;
      r_acc     <= 1'b0;
      r_arm     <= 1'b0;
      r_start   <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_start <= 1'b0;
      if (w_edge || !w_diff) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_CYCLES - 16'd1) begin
        r_deb_cnt <= '0;
        r_acc     <= r_sync2;
        if (!r_sync2) r_arm <= 1'b1;
        if (r_sync2 && !r_acc && r_arm) r_start <= 1'b1;
      end else begin
        r_deb_cnt <= r_deb_cnt + 16'd1;
      end
    end
  end

  // ---------------- classification ----------------
  logic [7:0] r_rx;
  logic [3:0] r_ref;

  logic [2:0] w_s;
  logic       w_g;
  logic       w_s0;
  logic [2:0] w_sh;
  logic [7:0] w_flip;
  logic [1:0] w_type;
  logic [2:0] w_pos;
  logic [7:0] w_corr;
  logic [3:0] w_cdata;
  logic       w_match;

  assign w_s  = chk_sindrome_i[2:0];
  assign w_g  = chk_sindrome_i[3];
  assign w_s0 = (w_s == 3'd0);
  // Hamming position k lives at bit 8-k.
  assign w_sh   = 3'(4'd8 - {1'b0, w_s});
  assign w_flip = 8'h01 << w_sh;

  always_comb begin
    w_type = 2'b00;
    w_pos  = 3'd0;
    w_corr = r_rx;
    unique case (1'b1)
      (w_s0 && !w_g): begin
        w_type = 2'b00;
      end
      (!w_s0 && w_g): begin
        w_type = 2'b01;
        w_pos  = w_s;
        w_corr = r_rx ^ w_flip;
      end
      (!w_s0 && !w_g): begin
        w_type = 2'b10;
      end
      default: begin
        w_type = 2'b11;
        w_corr = r_rx ^ 8'h01;
      end
    endcase
  end

  assign w_cdata = {w_corr[5], w_corr[3], w_corr[2], w_corr[1]};
  assign w_match = (w_cdata == r_ref) && (w_type != 2'b10);

  // ---------------- sequencer ----------------
  state_t        r_state;
  logic [WW-1:0] r_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_rx        <= '0;
      r_ref       <= '0;
      busy_o      <= 1'b0;
      valid_o     <= 1'b0;
      err_type_o  <= '0;
      err_pos_o   <= '0;
      corr_word_o <= '0;
      corr_data_o <= '0;
      match_o     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (r_start) begin
            r_state <= S_CAPTURE;
            busy_o  <= 1'b1;
            valid_o <= 1'b0;
          end
        end
        S_CAPTURE: begin
          r_rx    <= conmutador_8;
          r_ref   <= conmutador_4;
          r_wait  <= '0;
          r_state <= (CHK_LAT == 1) ? S_CLASSIFY : S_WAIT;
        end
        S_WAIT: begin
          if (r_wait == WAIT_LAST) r_state <= S_CLASSIFY;
          else r_wait <= r_wait + 1'b1;
        end
        S_CLASSIFY: begin
          err_type_o  <= w_type;
          err_pos_o   <= w_pos;
          corr_word_o <= w_corr;
          corr_data_o <= w_cdata;
          match_o     <= w_match;
          valid_o     <= 1'b1;
          busy_o      <= 1'b0;
          r_state     <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign chk_word_o = r_rx;

endmodule
